// File: rtl/rk4_solver_core_pkg.sv
// rk4_pkg: shared types and constants for the RK4 solver core.
//   rk4_state_t  - solver FSM states (IDLE, LOAD, K1..K4 x {AX,BY,H}, ACC, DONE)
//   one_sixth()  - round(2^frac / 6) in the fixed-point format
//   sat_max()    - largest signed value representable in 'width' bits
//   sat_min()    - smallest signed value representable in 'width' bits
package rk4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    K1_AX, K1_BY, K1_H,
    K2_AX, K2_BY, K2_H,
    K3_AX, K3_BY, K3_H,
    K4_AX, K4_BY, K4_H,
    ACC,
    DONE
  } rk4_state_t;

  function automatic longint one_sixth(input int unsigned frac);
    return ((longint'(1) << frac) + 3) / 6;
  endfunction

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/rk4_solver_core_fx_mul_sat.sv
// fx_mul_sat: combinational signed fixed-point multiply.
//   p, q - signed Q(WIDTH-FRAC).FRAC operands
//   r    - (p*q) >>> FRAC, truncated, saturated to WIDTH bits
//   sat  - high when r was clamped
module fx_mul_sat
  import rk4_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] p,
  input  logic signed [WIDTH-1:0] q,
  output logic signed [WIDTH-1:0] r,
  output logic                    sat
);

  localparam logic signed [2*WIDTH-1:0] MAX_W = (2*WIDTH)'(sat_max(WIDTH));
  localparam logic signed [2*WIDTH-1:0] MIN_W = (2*WIDTH)'(sat_min(WIDTH));

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;

  always_comb begin
    prod    = (2*WIDTH)'(p) * (2*WIDTH)'(q);
    shifted = prod >>> FRAC;
    sat     = 1'b0;
    r       = shifted[WIDTH-1:0];
    if (shifted > MAX_W) begin
      r   = MAX_W[WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_W) begin
      r   = MIN_W[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/rk4_solver_core.sv
// rk4_solver_core: fixed-point RK4 integrator for dy/dx = a*x + b*y.
//   clk, rst_n          - clock (rising edge), async active-low reset
//   start               - begin a solve (sampled in IDLE only)
//   x0, y0, a, b, h     - initial point, coefficients, step (signed fixed-point)
//   n_iter              - number of RK4 steps
//   busy, done          - handshake: busy during the solve, one-cycle done pulse
//   x_out, y_out        - current/final point, updated once per step
//   iter_cnt            - completed steps
//   overflow            - sticky saturation flag for the current solve
// One shared multiplier; each k takes 3 cycles, plus 1 accumulate cycle per step.
module rk4_solver_core
  import rk4_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned ITER_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] h,
  input  logic [ITER_W-1:0]       n_iter,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic [ITER_W-1:0]       iter_cnt,
  output logic                    overflow
);

  localparam logic signed [WIDTH-1:0] MAX_N     = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_N     = WIDTH'(sat_min(WIDTH));
  localparam logic signed [WIDTH+2:0] MAX_S     = (WIDTH+3)'(MAX_N);
  localparam logic signed [WIDTH+2:0] MIN_S     = (WIDTH+3)'(MIN_N);
  localparam logic signed [WIDTH-1:0] ONE_SIXTH = WIDTH'(one_sixth(FRAC));

  rk4_state_t state, state_nxt;

  logic signed [WIDTH-1:0] a_r, b_r, h_r, t_r, k1, k2, k3, k4;
  logic [ITER_W-1:0]       n_r;

  logic signed [WIDTH-1:0] mul_p, mul_q, mul_r;
  logic                    mul_sat, op_ovf, step_sat;
  logic [WIDTH:0]          x_half, x_acc, t_acc, y_acc, sum_sat;
  logic signed [WIDTH+2:0] wsum;

  // Returns {saturated, value}.
  function automatic logic [WIDTH:0] add_sat(input logic signed [WIDTH-1:0] u,
                                             input logic signed [WIDTH-1:0] v);
    logic [WIDTH:0] s;
    s = {u[WIDTH-1], u} + {v[WIDTH-1], v};
    if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MIN_N : MAX_N)};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
    .p  (mul_p),
    .q  (mul_q),
    .r  (mul_r),
    .sat(mul_sat)
  );

  always_comb begin
    x_half = add_sat(x_out, h_r >>> 1);
    x_acc  = add_sat(x_out, h_r);
    t_acc  = add_sat(t_r, mul_r);
    y_acc  = add_sat(y_out, mul_r);
    // k1 + 2*k2 + 2*k3 + k4 fits in WIDTH+3 bits; clamp once at the end.
    wsum   = (WIDTH+3)'(k1) + ((WIDTH+3)'(k2) <<< 1)
           + ((WIDTH+3)'(k3) <<< 1) + (WIDTH+3)'(k4);
    if (wsum > MAX_S)      sum_sat = {1'b1, MAX_N};
    else if (wsum < MIN_S) sum_sat = {1'b1, MIN_N};
    else                   sum_sat = {1'b0, wsum[WIDTH-1:0]};
  end

  always_comb begin
    state_nxt = state;
    mul_p     = '0;
    mul_q     = '0;
    op_ovf    = 1'b0;
    step_sat  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = (n_iter == '0) ? DONE : K1_AX;
      K1_AX: begin mul_p = a_r; mul_q = x_out;               state_nxt = K1_BY; end
      K2_AX: begin mul_p = a_r; {op_ovf, mul_q} = x_half;    state_nxt = K2_BY; end
      K3_AX: begin mul_p = a_r; {op_ovf, mul_q} = x_half;    state_nxt = K3_BY; end
      K4_AX: begin mul_p = a_r; {op_ovf, mul_q} = x_acc;     state_nxt = K4_BY; end
      K1_BY: begin mul_p = b_r; mul_q = y_out;               state_nxt = K1_H;  end
      K2_BY: begin mul_p = b_r; {op_ovf, mul_q} = add_sat(y_out, k1 >>> 1); state_nxt = K2_H; end
      K3_BY: begin mul_p = b_r; {op_ovf, mul_q} = add_sat(y_out, k2 >>> 1); state_nxt = K3_H; end
      K4_BY: begin mul_p = b_r; {op_ovf, mul_q} = add_sat(y_out, k3);       state_nxt = K4_H; end
      K1_H:  begin mul_p = h_r; mul_q = t_r; state_nxt = K2_AX; end
      K2_H:  begin mul_p = h_r; mul_q = t_r; state_nxt = K3_AX; end
      K3_H:  begin mul_p = h_r; mul_q = t_r; state_nxt = K4_AX; end
      K4_H:  begin mul_p = h_r; mul_q = t_r; state_nxt = ACC;   end
      ACC: begin
        mul_p           = ONE_SIXTH;
        {op_ovf, mul_q} = sum_sat;
        state_nxt       = (iter_cnt + ITER_W'(1) == n_r) ? DONE : K1_AX;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state)
      K1_AX, K2_AX, K3_AX, K4_AX: step_sat = mul_sat | op_ovf;
      K1_BY, K2_BY, K3_BY, K4_BY: step_sat = mul_sat | op_ovf | t_acc[WIDTH];
      K1_H, K2_H, K3_H, K4_H:     step_sat = mul_sat;
      ACC:     step_sat = mul_sat | op_ovf | y_acc[WIDTH] | x_acc[WIDTH];
      default: step_sat = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      iter_cnt <= '0;
      a_r      <= '0;
      b_r      <= '0;
      h_r      <= '0;
      n_r      <= '0;
      t_r      <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      k4       <= '0;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      overflow <= overflow | step_sat;
      case (state)
        LOAD: begin
          a_r      <= a;
          b_r      <= b;
          h_r      <= h;
          n_r      <= n_iter;
          x_out    <= x0;
          y_out    <= y0;
          iter_cnt <= '0;
          overflow <= 1'b0;
          busy     <= 1'b1;
        end
        K1_AX, K2_AX, K3_AX, K4_AX: t_r <= mul_r;
        K1_BY, K2_BY, K3_BY, K4_BY: t_r <= t_acc[WIDTH-1:0];
        K1_H: k1 <= mul_r;
        K2_H: k2 <= mul_r;
        K3_H: k3 <= mul_r;
        K4_H: k4 <= mul_r;
        ACC: begin
          y_out    <= y_acc[WIDTH-1:0];
          x_out    <= x_acc[WIDTH-1:0];
          iter_cnt <= iter_cnt + ITER_W'(1);
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
